// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions: memory word/mask widths and the
// memory arbiter state encoding.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT_A = 2'b01,
    GRANT_B = 2'b10
  } lc3b_arb_state;

endpackage

// File: rtl/mem_arbiter_control.sv
// Arbiter FSM, tie-break pointer and grant decode for mem_arbiter.
// Define MEM_ARB_RR_EN for round-robin ties; otherwise B always wins a tie.
module mem_arbiter_control
  import lc3b_types::*;
(
  input  logic clk,
  input  logic reset,
  input  logic a_req,
  input  logic b_req,
  input  logic pmem_resp,
  output logic grant_a,
  output logic grant_b
);

  lc3b_arb_state state, next_state;
  logic          pick_b;

`ifdef MEM_ARB_RR_EN
  // Cleared on reset so the first tie goes to B.
  logic last_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_b <= 1'b0;
    else if (state == IDLE && (a_req || b_req))
      last_b <= pick_b;
  end

  assign pick_b = b_req && (!a_req || !last_b);
`else
  assign pick_b = b_req;
`endif

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  // NOTE: every output gets a default first so no path leaves a value
  // unassigned, which would infer a latch.
  always_comb begin
    next_state = state;
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    unique case (state)
      IDLE: begin
        if (a_req || b_req)
          next_state = pick_b ? GRANT_B : GRANT_A;
      end
      GRANT_A: begin
        // A grant lapses the moment its owner drops both strobes.
        grant_a = a_req;
        if (!a_req || pmem_resp)
          next_state = IDLE;
      end
      GRANT_B: begin
        grant_b = b_req;
        if (!b_req || pmem_resp)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing the LC-3b physical memory between the instruction
// (A) and data (B) sides. Tie policy selected by MEM_ARB_RR_EN.
module mem_arbiter
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          reset,

  input  logic          a_read,
  input  logic          a_write,
  input  lc3b_word      a_address,
  input  lc3b_word      a_wdata,
  input  lc3b_mem_wmask a_byte_enable,
  output logic          a_resp,
  output lc3b_word      a_rdata,

  input  logic          b_read,
  input  logic          b_write,
  input  lc3b_word      b_address,
  input  lc3b_word      b_wdata,
  input  lc3b_mem_wmask b_byte_enable,
  output logic          b_resp,
  output lc3b_word      b_rdata,

  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_word      pmem_address,
  output lc3b_word      pmem_wdata,
  output lc3b_mem_wmask pmem_byte_enable,
  input  logic          pmem_resp,
  input  lc3b_word      pmem_rdata
);

  logic grant_a, grant_b;

  mem_arbiter_control u_control (
    .clk       (clk),
    .reset     (reset),
    .a_req     (a_read | a_write),
    .b_req     (b_read | b_write),
    .pmem_resp (pmem_resp),
    .grant_a   (grant_a),
    .grant_b   (grant_b)
  );

  // A simultaneous read and write is treated as a write.
  always_comb begin
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    pmem_address     = '0;
    pmem_wdata       = '0;
    pmem_byte_enable = '0;
    if (grant_a) begin
      pmem_read        = a_read & ~a_write;
      pmem_write       = a_write;
      pmem_address     = a_address;
      pmem_wdata       = a_wdata;
      pmem_byte_enable = a_byte_enable;
    end else if (grant_b) begin
      pmem_read        = b_read & ~b_write;
      pmem_write       = b_write;
      pmem_address     = b_address;
      pmem_wdata       = b_wdata;
      pmem_byte_enable = b_byte_enable;
    end
  end

  assign a_resp  = grant_a & pmem_resp;
  assign b_resp  = grant_b & pmem_resp;
  assign a_rdata = pmem_rdata;
  assign b_rdata = pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of single-port transactions,
// hand-written tie/starvation/reset/abort sequences, response scoreboard.
module tb_mem_arbiter;

  logic        clk, reset;
  logic        a_read, a_write, b_read, b_write;
  logic [15:0] a_address, a_wdata, b_address, b_wdata;
  logic [1:0]  a_byte_enable, b_byte_enable;
  logic        a_resp, b_resp;
  logic [15:0] a_rdata, b_rdata;
  logic        pmem_read, pmem_write, pmem_resp;
  logic [15:0] pmem_address, pmem_wdata, pmem_rdata;
  logic [1:0]  pmem_byte_enable;

  int checks = 0;
  int errors = 0;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // Scoreboard entries: {port is B, read data}.
  logic [16:0] sb[$];

  typedef struct {
    logic        is_b;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    int          lat;
    logic [15:0] rdata;
  } vec_t;

  vec_t vecs[5];

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .a_read(a_read), .a_write(a_write), .a_address(a_address),
    .a_wdata(a_wdata), .a_byte_enable(a_byte_enable),
    .a_resp(a_resp), .a_rdata(a_rdata),
    .b_read(b_read), .b_write(b_write), .b_address(b_address),
    .b_wdata(b_wdata), .b_byte_enable(b_byte_enable),
    .b_resp(b_resp), .b_rdata(b_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_byte_enable(pmem_byte_enable),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Any response must match the oldest expected completion.
  always @(negedge clk) begin
    if (a_resp || b_resp) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", {a_resp, b_resp}, 2'b00);
      end else begin
        logic [16:0] e;
        e = sb.pop_front();
        check("sb_resp_port", {a_resp, b_resp}, e[16] ? 2'b01 : 2'b10);
        check("sb_rdata", e[16] ? b_rdata : a_rdata, e[15:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic is_b, input logic rd, input logic wr,
                       input logic [15:0] addr, input logic [15:0] wdata,
                       input logic [1:0] be);
    if (is_b) begin
      b_read = rd; b_write = wr; b_address = addr; b_wdata = wdata; b_byte_enable = be;
    end else begin
      a_read = rd; a_write = wr; a_address = addr; a_wdata = wdata; a_byte_enable = be;
    end
  endtask

  task automatic clear(input logic is_b);
    drive(is_b, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pmem_strobes"}, {pmem_read, pmem_write}, 2'b00);
    check({tag, "_pmem_address"}, pmem_address, 16'h0);
    check({tag, "_pmem_wdata"}, pmem_wdata, 16'h0);
    check({tag, "_pmem_be"}, pmem_byte_enable, 2'b00);
    check({tag, "_resps"}, {a_resp, b_resp}, 2'b00);
  endtask

  // Called in an IDLE cycle with requests already driven. Expects the given
  // port granted next cycle and memory answering after lat cycles.
  task automatic run_grant(input logic exp_b, input int lat, input logic [15:0] rdata);
    logic er, ew;
    logic [15:0] ea, ed;
    logic [1:0] eb;
    @(negedge clk);
    check("idle_strobes", {pmem_read, pmem_write}, 2'b00);
    tick();
    er = exp_b ? b_read : a_read;
    ew = exp_b ? b_write : a_write;
    ea = exp_b ? b_address : a_address;
    ed = exp_b ? b_wdata : a_wdata;
    eb = exp_b ? b_byte_enable : a_byte_enable;
    for (int c = 1; c <= lat; c++) begin
      if (c == lat) begin
        pmem_resp  = 1'b1;
        pmem_rdata = rdata;
        sb.push_back({exp_b, rdata});
      end
      @(negedge clk);
      check("pmem_read", pmem_read, er & ~ew);
      check("pmem_write", pmem_write, ew);
      check("pmem_address", pmem_address, ea);
      check("pmem_wdata", pmem_wdata, ed);
      check("pmem_be", pmem_byte_enable, eb);
      check("a_resp", a_resp, !exp_b && c == lat);
      check("b_resp", b_resp, exp_b && c == lat);
      tick();
    end
    pmem_resp = 1'b0;
    clear(exp_b);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b0, 16'h3000, 16'h0000, 2'b00, 3, 16'h1234};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 16'h4000, 16'hBEEF, 2'b01, 1, 16'h0000};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 16'h5000, 16'h1111, 2'b11, 2, 16'h2222};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 16'h6002, 16'h0000, 2'b00, 2, 16'hCAFE};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 16'h0010, 16'h00FF, 2'b10, 1, 16'h0000};

    reset = 1'b1;
    pmem_resp = 1'b0;
    pmem_rdata = 16'h0;
    clear(1'b0);
    clear(1'b1);
    #2;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Single-port transactions, including read+write collapsing to write.
    foreach (vecs[i]) begin
      drive(vecs[i].is_b, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be);
      run_grant(vecs[i].is_b, vecs[i].lat, vecs[i].rdata);
    end

    // Tie from reset: B first, then A after one IDLE cycle.
    reset_dut();
    drive(1'b0, 1'b1, 1'b0, 16'h3000, 16'h0, 2'b00);
    drive(1'b1, 1'b0, 1'b1, 16'h4000, 16'hBEEF, 2'b01);
    run_grant(1'b1, 1, 16'h0000);
    run_grant(1'b0, 1, 16'h3333);
    // B alone, then a second tie: round-robin now favours A.
    drive(1'b1, 1'b1, 1'b0, 16'h4100, 16'h0, 2'b00);
    run_grant(1'b1, 1, 16'h4444);
    drive(1'b0, 1'b1, 1'b0, 16'h3100, 16'h0, 2'b00);
    drive(1'b1, 1'b1, 1'b0, 16'h4200, 16'h0, 2'b00);
    run_grant(!RR, 2, 16'h5555);
    run_grant(RR, 1, 16'h6666);

    // Continuous B traffic with A pending.
    reset_dut();
    drive(1'b0, 1'b1, 1'b0, 16'h1000, 16'h0, 2'b00);
    for (int i = 0; i < 20; i++) begin
      logic exp_b;
      exp_b = RR ? (i % 2 == 0) : 1'b1;
      drive(1'b1, 1'b1, 1'b0, 16'h7000 + 16'(i), 16'h0, 2'b00);
      run_grant(exp_b, 1, 16'hA000 + 16'(i));
      if (!exp_b)
        drive(1'b0, 1'b1, 1'b0, 16'h1000, 16'h0, 2'b00);
    end
    clear(1'b1);
    if (a_read)
      run_grant(1'b0, 1, 16'h1001);

    // Reset during GRANT_B: outputs clear at once, late response ignored.
    drive(1'b1, 1'b0, 1'b1, 16'h4000, 16'hBEEF, 2'b01);
    @(negedge clk);
    tick();
    @(negedge clk);
    check("pre_reset_write", pmem_write, 1'b1);
    tick();
    reset = 1'b1;
    clear(1'b1);
    #1;
    check_all_zero("async_reset");
    tick();
    reset = 1'b0;
    pmem_resp = 1'b1;
    pmem_rdata = 16'h5A5A;
    @(negedge clk);
    check("late_resp_b", b_resp, 1'b0);
    check("late_resp_strobes", {pmem_read, pmem_write}, 2'b00);
    tick();
    pmem_resp = 1'b0;

    // Granted A aborts; pending B served afterwards, A never responds.
    drive(1'b0, 1'b1, 1'b0, 16'h2000, 16'h0, 2'b00);
    @(negedge clk);
    tick();
    drive(1'b1, 1'b1, 1'b0, 16'h8000, 16'h0, 2'b00);
    @(negedge clk);
    check("abort_granted", {pmem_read, pmem_address}, {1'b1, 16'h2000});
    tick();
    clear(1'b0);
    @(negedge clk);
    check_all_zero("abort_same_cycle");
    tick();
    run_grant(1'b1, 2, 16'h8888);

    repeat (2) @(posedge clk);
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
